// File: rtl/cv32e40p_pdl_pkg.sv
// Shared state type, defaults and helpers for the PDL alarm controller.
package cv32e40p_pdl_pkg;

    localparam int N_SENS_DEF = 4;
    localparam int WARMUP_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_MONITOR = 3'd2,
        ST_LOCKOUT = 3'd3
    } pdl_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] val);
        return (val == 4'hF) ? val : val + 4'd1;
    endfunction

endpackage

// File: rtl/cv32e40p_pdl_window_cnt.sv
// Loadable down-counter that pulses o_wrap on its terminal count and reloads itself.
// A zero length loaded at any load point makes the window unbounded (never wraps).
module cv32e40p_pdl_window_cnt #(
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIN_W-1:0] i_len,
    output logic             o_wrap
);

    logic [WIN_W-1:0] r_cnt;
    logic             r_unbounded;

    assign o_wrap = i_en && !r_unbounded && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_unbounded <= 1'b0;
        end else if (i_clr) begin
            r_cnt       <= '0;
            r_unbounded <= 1'b0;
        end else if (i_load || o_wrap) begin
            r_cnt       <= i_len - WIN_W'(1);
            r_unbounded <= (i_len == '0);
        end else if (i_en && !r_unbounded) begin
            r_cnt <= r_cnt - WIN_W'(1);
        end
    end

endmodule

// File: rtl/cv32e40p_pdl_alarm_ctrl.sv
// PDL alarm controller: warms up the sensors, counts windowed alarms and
// locks the core out with a halt request once the alarm threshold is reached.
module cv32e40p_pdl_alarm_ctrl
    import cv32e40p_pdl_pkg::*;
#(
    parameter int N_SENS = N_SENS_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int WIN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [N_SENS-1:0] cfg_mask,
    input  logic [3:0]        cfg_thresh,
    input  logic [WIN_W-1:0]  cfg_window,
    input  logic              clear_i,
    input  logic [N_SENS-1:0] alarm_i,
    output logic [N_SENS-1:0] sensor_en_o,
    output logic              irq_o,
    output logic              halt_req_o,
    output logic [N_SENS-1:0] status_o,
    output logic [3:0]        alarm_cnt_o,
    output logic [2:0]        state_o
);

    localparam int              WU_W    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WU_W-1:0] WU_LOAD = WU_W'(WARMUP - 1);

    pdl_state_e        r_state, w_state_nxt;
    logic [WU_W-1:0]   r_warm, w_warm_nxt;
    logic [N_SENS-1:0] r_sensor_en, w_sensor_en_nxt;
    logic [N_SENS-1:0] r_status, w_status_nxt;
    logic [N_SENS-1:0] w_masked;
    logic              r_irq, w_irq_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt, w_cnt_base;
    logic              w_hit;
    logic              w_win_load, w_win_clr, w_win_en, w_win_wrap;

    assign w_masked = alarm_i & cfg_mask;
    assign w_hit    = |w_masked;
    assign w_win_en = (r_state == ST_MONITOR) && cfg_en;

    cv32e40p_pdl_window_cnt #(.WIN_W(WIN_W)) u_window_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_win_clr),
        .i_load (w_win_load),
        .i_en   (w_win_en),
        .i_len  (cfg_window),
        .o_wrap (w_win_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_warm      <= '0;
            r_sensor_en <= '0;
            r_status    <= '0;
            r_irq       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_warm      <= w_warm_nxt;
            r_sensor_en <= w_sensor_en_nxt;
            r_status    <= w_status_nxt;
            r_irq       <= w_irq_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Clear outside LOCKOUT is applied first so a same-cycle alarm overrides it.
    always_comb begin
        w_state_nxt  = r_state;
        w_warm_nxt   = r_warm;
        w_status_nxt = r_status;
        w_irq_nxt    = r_irq;
        w_cnt_nxt    = r_cnt;
        w_cnt_base   = r_cnt;
        w_win_load   = 1'b0;
        w_win_clr    = 1'b0;

        if (clear_i && (r_state != ST_LOCKOUT)) begin
            w_status_nxt = '0;
            w_irq_nxt    = 1'b0;
            w_cnt_nxt    = '0;
        end

        case (r_state)
            ST_IDLE: begin
                if (cfg_en) begin
                    w_state_nxt = ST_ARM;
                    w_warm_nxt  = WU_LOAD;
                end
            end
            ST_ARM: begin
                if (!cfg_en) begin
                    w_state_nxt = ST_IDLE;
                    w_warm_nxt  = '0;
                    w_win_clr   = 1'b1;
                end else if (r_warm == '0) begin
                    w_state_nxt = ST_MONITOR;
                    w_win_load  = 1'b1;
                end else begin
                    w_warm_nxt = r_warm - WU_W'(1);
                end
            end
            ST_MONITOR: begin
                if (!cfg_en) begin
                    w_state_nxt = ST_IDLE;
                    w_warm_nxt  = '0;
                    w_win_clr   = 1'b1;
                end else begin
                    w_cnt_base = (clear_i || w_win_wrap) ? 4'd0 : r_cnt;
                    w_cnt_nxt  = w_cnt_base;
                    if (w_hit) begin
                        w_status_nxt = w_status_nxt | w_masked;
                        w_irq_nxt    = 1'b1;
                        w_cnt_nxt    = sat_inc4(w_cnt_base);
                        if ((cfg_thresh != 4'd0) && (w_cnt_nxt >= cfg_thresh)) begin
                            w_state_nxt = ST_LOCKOUT;
                        end
                    end
                end
            end
            ST_LOCKOUT: begin
                if (clear_i) begin
                    w_status_nxt = '0;
                    w_irq_nxt    = 1'b0;
                    w_cnt_nxt    = '0;
                    if (cfg_en) begin
                        w_state_nxt = ST_ARM;
                        w_warm_nxt  = WU_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_warm_nxt  = '0;
                        w_win_clr   = 1'b1;
                    end
                end else if (w_hit) begin
                    w_status_nxt = r_status | w_masked;
                    w_irq_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_sensor_en_nxt = (w_state_nxt == ST_IDLE) ? '0 : cfg_mask;
    end

    assign sensor_en_o = r_sensor_en;
    assign irq_o       = r_irq;
    assign halt_req_o  = (r_state == ST_LOCKOUT);
    assign status_o    = r_status;
    assign alarm_cnt_o = r_cnt;
    assign state_o     = r_state;

endmodule
